exe_mem_pipe_reg: RTL



---
 rtl/pipe_pkg.sv | 40 ++++
 rtl/pipe_skid_buf.sv | 128 ++++++++++++
 rtl/exe_mem_pipe_reg.sv | 101 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared types and default widths for the EXE/MEM pipeline register.
//   - pipe_state_t      : occupancy state of the two-entry skid buffer
//   - *_DEF             : default field widths for the filter processor
//   - exe_mem_payload_t : packed EXE/MEM payload at the default widths
//   - state_count()     : number of entries held in a given state
package pipe_pkg;

    localparam int CTRL_W_DEF      = 17;
    localparam int DATA_W_DEF      = 32;
    localparam int DIR_W_DEF       = 4;
    localparam int STALL_CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // Field order here matches the packing order used by the top level.
    typedef struct packed {
        logic [CTRL_W_DEF-1:0] ctrl;
        logic [DATA_W_DEF-1:0] src_reg;
        logic [DIR_W_DEF-1:0]  src_reg_dir;
        logic [DATA_W_DEF-1:0] alu;
        logic [DATA_W_DEF-1:0] robj;
    } exe_mem_payload_t;

    function automatic logic [1:0] state_count(input pipe_state_t st);
        logic [1:0] cnt;
        case (st)
            EMPTY:   cnt = 2'd0;
            ONE:     cnt = 2'd1;
            FULL:    cnt = 2'd2;
            default: cnt = 2'd0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf
//   Generic two-entry skid buffer with valid/ready on both sides.
//   The main register drives out_data; the skid register catches the one
//   entry that can arrive while the downstream side stalls. in_ready is
//   computed from the next state and registered, so out_ready never
//   reaches in_ready combinationally.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush                drop all held entries (takes priority)
//   in_valid/in_ready    upstream handshake (in_ready registered)
//   in_data              upstream payload
//   out_valid/out_ready  downstream handshake (out_valid registered)
//   out_data             main register contents
//   count                entries held (0..2), registered
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           count
);

    pipe_state_t          state_r;
    pipe_state_t          state_nxt_s;
    logic [PAYLOAD_W-1:0] main_r;
    logic [PAYLOAD_W-1:0] skid_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [1:0]           count_r;
    logic                 accept_s;
    logic                 emit_s;
    logic                 load_main_in_s;
    logic                 load_main_skid_s;
    logic                 load_skid_s;

    assign accept_s  = in_valid & in_ready_r;
    assign emit_s    = out_valid_r & out_ready;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;
    assign count     = count_r;

    // Next-state and register-load selection; flush overrides everything.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s    = ONE;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && !emit_s) begin
                        state_nxt_s = FULL;
                        load_skid_s = 1'b1;
                    end else if (accept_s && emit_s) begin
                        state_nxt_s    = ONE;
                        load_main_in_s = 1'b1;
                    end else if (emit_s) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = ONE;
                    end
                end
                FULL: begin
                    // in_ready is low here, so no accept can coincide.
                    if (emit_s) begin
                        state_nxt_s      = ONE;
                        load_main_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
                default: begin
                    state_nxt_s = EMPTY;
                end
            endcase
        end
    end

    // State, handshake flags, occupancy and payload registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            count_r     <= 2'd0;
            main_r      <= {PAYLOAD_W{1'b0}};
            skid_r      <= {PAYLOAD_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != FULL);
            out_valid_r <= (state_nxt_s != EMPTY);
            count_r     <= state_count(state_nxt_s);
            if (load_main_in_s) begin
                main_r <= in_data;
            end else if (load_main_skid_s) begin
                main_r <= skid_r;
            end else begin
                main_r <= main_r;
            end
            if (load_skid_s) begin
                skid_r <= in_data;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// exe_mem_pipe_reg
//   EXE/MEM stage register of the filter processor with a valid/ready
//   handshake, two-entry skid buffer, flush, occupancy and stall counter.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    discard held entries; o_ctrl reads 0 afterwards
//   in_valid/in_ready        upstream handshake (in_ready registered)
//   i_ctrl..i_Robj           payload from execute stage
//   out_valid/out_ready      downstream handshake
//   o_ctrl..o_Robj           payload to memory stage
//   o_count                  entries held (0..2)
//   o_stall_cnt              saturating count of out_valid & !out_ready cycles
module exe_mem_pipe_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W      = CTRL_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DIR_W       = DIR_W_DEF,
    parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      i_ctrl,
    input  logic [DATA_W-1:0]      i_srcReg,
    input  logic [DIR_W-1:0]       i_srcRegDir,
    input  logic [DATA_W-1:0]      i_alu,
    input  logic [DATA_W-1:0]      i_Robj,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      o_ctrl,
    output logic [DATA_W-1:0]      o_srcReg,
    output logic [DIR_W-1:0]       o_srcRegDir,
    output logic [DATA_W-1:0]      o_alu,
    output logic [DATA_W-1:0]      o_Robj,
    output logic [1:0]             o_count,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    localparam int PAYLOAD_W = CTRL_W + 3 * DATA_W + DIR_W;

    logic [PAYLOAD_W-1:0]   in_data_s;
    logic [PAYLOAD_W-1:0]   out_data_s;
    logic [CTRL_W-1:0]      main_ctrl_s;
    logic                   out_valid_s;
    logic                   ctrl_zero_r;
    logic [STALL_CNT_W-1:0] stall_cnt_r;

    assign in_data_s = {i_ctrl, i_srcReg, i_srcRegDir, i_alu, i_Robj};

    pipe_skid_buf #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_data  (out_data_s),
        .count     (o_count)
    );

    assign {main_ctrl_s, o_srcReg, o_srcRegDir, o_alu, o_Robj} = out_data_s;
    assign out_valid = out_valid_s;

    // After a flush the main register still holds the old control word;
    // mask it until a fresh entry makes out_valid rise (that edge reloads main).
    assign o_ctrl = (ctrl_zero_r && !out_valid_s) ? {CTRL_W{1'b0}} : main_ctrl_s;

    // Tracks whether the visible control word has been bubbled by a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_zero_r <= 1'b0;
        end else if (flush) begin
            ctrl_zero_r <= 1'b1;
        end else if (out_valid_s) begin
            ctrl_zero_r <= 1'b0;
        end else begin
            ctrl_zero_r <= ctrl_zero_r;
        end
    end

    // Saturating stall counter; flush intentionally leaves it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (out_valid_s && !out_ready && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign o_stall_cnt = stall_cnt_r;

endmodule
